// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle load/store unit in front of the memory bridge.
// Optional MAU_STAT_CNT_EN adds completed load/store counters.
module mem_access_unit #(
  parameter int unsigned RD_LATENCY = 0
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iReqValid,
  output logic        oReqReady,
  input  logic        iReqWrite,
  input  logic [63:0] iReqAddr,
  input  logic [63:0] iReqData,
  input  logic [1:0]  iReqSize,
  input  logic        iReqSigned,
  output logic        oRespValid,
  input  logic        iRespReady,
  output logic [63:0] oRespData,
  output logic        oRespErr,
  output logic        oMemRdEn,
  output logic [63:0] oMemRdAddrLoad,
  input  logic [63:0] iMemRdDataLoad,
  output logic        oMemWrEn,
  output logic [63:0] oMemWrAddr,
  output logic [63:0] oMemWrData,
  output logic [7:0]  oMemWrLen,
  output logic [31:0] oLoadCnt,
  output logic [31:0] oStoreCnt
);

  typedef enum logic [1:0] {
    IDLE, ACCESS, WAIT, RESP
  } state_t;

  localparam logic [31:0] LAST =
    (RD_LATENCY > 0) ? 32'(RD_LATENCY - 1) : 32'd0;

  state_t state, state_nxt;

  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_data;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [63:0] resp_data;
  logic        resp_err;
  logic [31:0] wait_cnt;
  logic        accept;
  logic        in_access;
  logic        sample;

  function automatic logic misaligned(
    input logic [2:0] a,
    input logic [1:0] s
  );
    unique case (s)
      2'd0:    return 1'b0;
      2'd1:    return a[0];
      2'd2:    return |a[1:0];
      default: return |a;
    endcase
  endfunction

  function automatic logic [63:0] extract(
    input logic [63:0] beat,
    input logic [2:0]  off,
    input logic [1:0]  s,
    input logic        sgn
  );
    logic [63:0] sh;
    sh = beat >> {off, 3'b000};
    unique case (s)
      2'd0:    return {{56{sgn & sh[7]}}, sh[7:0]};
      2'd1:    return {{48{sgn & sh[15]}}, sh[15:0]};
      2'd2:    return {{32{sgn & sh[31]}}, sh[31:0]};
      default: return sh;
    endcase
  endfunction

  function automatic logic [63:0] mask_data(
    input logic [63:0] d,
    input logic [1:0]  s
  );
    unique case (s)
      2'd0:    return {56'd0, d[7:0]};
      2'd1:    return {48'd0, d[15:0]};
      2'd2:    return {32'd0, d[31:0]};
      default: return d;
    endcase
  endfunction

  assign accept    = (state == IDLE) && iReqValid;
  assign in_access = (state == ACCESS);
  assign sample    =
    (in_access && !req_write && RD_LATENCY == 0) ||
    ((state == WAIT) && (wait_cnt == LAST));

  // State register; reset drops any in-flight access.
  always_ff @(posedge iClock) begin
    if (!iReset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (iReqValid)
          state_nxt = misaligned(iReqAddr[2:0], iReqSize)
                      ? RESP : ACCESS;
      end
      ACCESS: begin
        if (req_write || RD_LATENCY == 0) state_nxt = RESP;
        else                              state_nxt = WAIT;
      end
      WAIT: begin
        if (wait_cnt == LAST) state_nxt = RESP;
      end
      default: begin
        if (iRespReady) state_nxt = IDLE;
      end
    endcase
  end

  // Request latch, read-wait counter and response capture.
  always_ff @(posedge iClock) begin
    if (!iReset) begin
      req_write  <= 1'b0;
      req_addr   <= '0;
      req_data   <= '0;
      req_size   <= '0;
      req_signed <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      if (accept) begin
        req_write  <= iReqWrite;
        req_addr   <= iReqAddr;
        req_data   <= iReqData;
        req_size   <= iReqSize;
        req_signed <= iReqSigned;
        resp_err   <= misaligned(iReqAddr[2:0], iReqSize);
        resp_data  <= '0;
        wait_cnt   <= '0;
      end
      if (state == WAIT) wait_cnt <= wait_cnt + 32'd1;
      if (sample)
        resp_data <= extract(iMemRdDataLoad, req_addr[2:0],
                             req_size, req_signed);
    end
  end

  assign oReqReady  = (state == IDLE);
  assign oRespValid = (state == RESP);
  assign oRespData  = (state == RESP) ? resp_data : '0;
  assign oRespErr   = (state == RESP) && resp_err;

  assign oMemRdEn       = in_access && !req_write;
  assign oMemRdAddrLoad =
    oMemRdEn ? {req_addr[63:3], 3'b000} : '0;

  assign oMemWrEn   = in_access && req_write;
  assign oMemWrAddr = oMemWrEn ? req_addr : '0;
  assign oMemWrData =
    oMemWrEn ? mask_data(req_data, req_size) : '0;
  assign oMemWrLen  =
    oMemWrEn ? (8'd1 << req_size) : 8'd0;

`ifdef MAU_STAT_CNT_EN
  logic [31:0] load_cnt;
  logic [31:0] store_cnt;
  logic        done;

  assign done = (state == RESP) && iRespReady && !resp_err;

  // Completed non-error access counters, wrapping.
  always_ff @(posedge iClock) begin
    if (!iReset) begin
      load_cnt  <= '0;
      store_cnt <= '0;
    end else if (done) begin
      if (req_write) store_cnt <= store_cnt + 32'd1;
      else           load_cnt  <= load_cnt + 32'd1;
    end
  end

  assign oLoadCnt  = load_cnt;
  assign oStoreCnt = store_cnt;
`else
  assign oLoadCnt  = '0;
  assign oStoreCnt = '0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of mem_access_unit
// with read latency 0 and 3.
module tb_mem_access_unit;

  localparam logic [63:0] BEAT = 64'h8877665544332211;
  localparam logic [63:0] BASE = 64'h0000000080000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst3, v0, v3;
  logic        wr, sgn, rr;
  logic [63:0] addr, wdata;
  logic [1:0]  size;

  logic        rdy0, rv0, rerr0, rden0, wren0;
  logic [63:0] rdata0, rdaddr0, mdata0;
  logic [63:0] wraddr0, wrdata0;
  logic [7:0]  wrlen0;
  logic [31:0] lcnt0, scnt0;

  logic        rdy3, rv3, rerr3, rden3, wren3;
  logic [63:0] rdata3, rdaddr3, mdata3;
  logic [63:0] wraddr3, wrdata3;
  logic [7:0]  wrlen3;
  logic [31:0] lcnt3, scnt3;
  logic [63:0] lat_addr = '0;

  int tests_run = 0;
  int tests_failed = 0;
  int exp_ld = 0;
  int exp_st = 0;

  assign mdata0 = (rdaddr0 == BASE) ? BEAT : '0;
  assign mdata3 = (lat_addr == BASE) ? BEAT : '0;

  always_ff @(posedge clk) if (rden3) lat_addr <= rdaddr3;

  mem_access_unit #(.RD_LATENCY(0)) dut (
    .iClock(clk), .iReset(rst0),
    .iReqValid(v0), .oReqReady(rdy0),
    .iReqWrite(wr), .iReqAddr(addr),
    .iReqData(wdata), .iReqSize(size),
    .iReqSigned(sgn),
    .oRespValid(rv0), .iRespReady(rr),
    .oRespData(rdata0), .oRespErr(rerr0),
    .oMemRdEn(rden0), .oMemRdAddrLoad(rdaddr0),
    .iMemRdDataLoad(mdata0),
    .oMemWrEn(wren0), .oMemWrAddr(wraddr0),
    .oMemWrData(wrdata0), .oMemWrLen(wrlen0),
    .oLoadCnt(lcnt0), .oStoreCnt(scnt0)
  );

  mem_access_unit #(.RD_LATENCY(3)) dut3 (
    .iClock(clk), .iReset(rst3),
    .iReqValid(v3), .oReqReady(rdy3),
    .iReqWrite(wr), .iReqAddr(addr),
    .iReqData(wdata), .iReqSize(size),
    .iReqSigned(sgn),
    .oRespValid(rv3), .iRespReady(rr),
    .oRespData(rdata3), .oRespErr(rerr3),
    .oMemRdEn(rden3), .oMemRdAddrLoad(rdaddr3),
    .iMemRdDataLoad(mdata3),
    .oMemWrEn(wren3), .oMemWrAddr(wraddr3),
    .oMemWrData(wrdata3), .oMemWrLen(wrlen3),
    .oLoadCnt(lcnt3), .oStoreCnt(scnt3)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue0(
    input logic        w,
    input logic [63:0] a,
    input logic [63:0] d,
    input logic [1:0]  s,
    input logic        g
  );
    wr = w; addr = a; wdata = d; size = s; sgn = g;
    v0 = 1'b1;
    step();
    v0 = 1'b0;
  endtask

  task automatic load0(
    input string       tag,
    input logic [63:0] a,
    input logic [1:0]  s,
    input logic        g,
    input logic [63:0] exp
  );
    issue0(1'b0, a, '0, s, g);
    check({tag, "_rden"}, 64'(rden0), 64'd1);
    check({tag, "_rdaddr"}, rdaddr0, BASE);
    check({tag, "_early"}, 64'(rv0), 64'd0);
    step();
    check({tag, "_rv"}, 64'(rv0), 64'd1);
    check({tag, "_data"}, rdata0, exp);
    check({tag, "_err"}, 64'(rerr0), 64'd0);
    check({tag, "_rdoff"}, rdaddr0, 64'd0);
    exp_ld++;
    step();
    check({tag, "_rdy"}, 64'(rdy0), 64'd1);
  endtask

  task automatic check_cnt(input string tag);
    logic [63:0] el, es;
`ifdef MAU_STAT_CNT_EN
    el = 64'(exp_ld);
    es = 64'(exp_st);
`else
    el = 64'd0;
    es = 64'd0;
`endif
    check({tag, "_lcnt"}, 64'(lcnt0), el);
    check({tag, "_scnt"}, 64'(scnt0), es);
  endtask

  initial begin
    logic [63:0] held;
    rst0 = 1'b0; rst3 = 1'b0;
    v0 = 1'b1; v3 = 1'b0; rr = 1'b1;
    wr = 1'b0; addr = BASE; wdata = '0;
    size = 2'd0; sgn = 1'b0;
    step(); step();
    check("rst_rdy", 64'(rdy0), 64'd1);
    check("rst_rv", 64'(rv0), 64'd0);
    check("rst_rden", 64'(rden0), 64'd0);
    check("rst_data", rdata0, 64'd0);
    rst0 = 1'b1; rst3 = 1'b1; v0 = 1'b0;
    step();
    check("post_rst_rden", 64'(rden0), 64'd0);
    check("post_rst_rdy", 64'(rdy0), 64'd1);
    check_cnt("rst");

    load0("ld_b", BASE + 3, 2'd0, 1'b0, 64'h44);
    load0("ld_hs", BASE + 6, 2'd1, 1'b1,
          64'hFFFFFFFFFFFF8877);
    load0("ld_wu", BASE + 4, 2'd2, 1'b0,
          64'h0000000088776655);
    load0("ld_ws", BASE + 4, 2'd2, 1'b1,
          64'hFFFFFFFF88776655);
    load0("ld_bs", BASE + 1, 2'd0, 1'b1, 64'h22);
    load0("ld_d", BASE, 2'd3, 1'b1, BEAT);

    issue0(1'b1, BASE + 4, 64'hDEADBEEFCAFEF00D,
           2'd2, 1'b0);
    check("st_wren", 64'(wren0), 64'd1);
    check("st_addr", wraddr0, BASE + 4);
    check("st_data", wrdata0, 64'hCAFEF00D);
    check("st_len", 64'(wrlen0), 64'd4);
    check("st_rden", 64'(rden0), 64'd0);
    step();
    check("st_wren_off", 64'(wren0), 64'd0);
    check("st_data_off", wrdata0, 64'd0);
    check("st_rv", 64'(rv0), 64'd1);
    check("st_rdata", rdata0, 64'd0);
    check("st_err", 64'(rerr0), 64'd0);
    exp_st++;
    step();

    issue0(1'b1, BASE + 8, 64'hDEADBEEFCAFEF00D,
           2'd3, 1'b0);
    check("std_len", 64'(wrlen0), 64'd8);
    check("std_data", wrdata0, 64'hDEADBEEFCAFEF00D);
    step();
    exp_st++;
    step();

    issue0(1'b1, BASE + 7, 64'h1234, 2'd0, 1'b0);
    check("stb_len", 64'(wrlen0), 64'd1);
    check("stb_data", wrdata0, 64'h34);
    step();
    exp_st++;
    step();

    issue0(1'b0, BASE + 2, '0, 2'd2, 1'b0);
    check("mis_rv", 64'(rv0), 64'd1);
    check("mis_err", 64'(rerr0), 64'd1);
    check("mis_data", rdata0, 64'd0);
    check("mis_rden", 64'(rden0), 64'd0);
    check("mis_rdy", 64'(rdy0), 64'd0);
    step();
    check("mis_back", 64'(rdy0), 64'd1);

    issue0(1'b1, BASE + 1, 64'hFF, 2'd1, 1'b0);
    check("mis_st_wren", 64'(wren0), 64'd0);
    check("mis_st_err", 64'(rerr0), 64'd1);
    step();

    rr = 1'b0;
    issue0(1'b0, BASE + 5, '0, 2'd0, 1'b1);
    step();
    held = rdata0;
    check("hold_data0", held, 64'h66);
    for (int i = 0; i < 5; i++) begin
      check("hold_rv", 64'(rv0), 64'd1);
      check("hold_data", rdata0, 64'h66);
      check("hold_rdy", 64'(rdy0), 64'd0);
      step();
    end
    rr = 1'b1;
    check("hold_last_rv", 64'(rv0), 64'd1);
    step();
    exp_ld++;
    check("hold_rdy_back", 64'(rdy0), 64'd1);
    check("hold_rv_off", 64'(rv0), 64'd0);
    check_cnt("end");

    wr = 1'b0; addr = BASE + 7; size = 2'd0; sgn = 1'b1;
    v3 = 1'b1;
    step();
    v3 = 1'b0;
    check("l3_rden", 64'(rden3), 64'd1);
    check("l3_rdaddr", rdaddr3, BASE);
    step();
    check("l3_t2", 64'(rv3), 64'd0);
    step();
    step();
    check("l3_t4", 64'(rv3), 64'd0);
    step();
    check("l3_t5", 64'(rv3), 64'd1);
    check("l3_data", rdata3, 64'hFFFFFFFFFFFFFF88);
    step();
    check("l3_rdy", 64'(rdy3), 64'd1);

    addr = BASE; size = 2'd3; sgn = 1'b0;
    v3 = 1'b1;
    step();
    v3 = 1'b0;
    step();
    check("w3_rdy", 64'(rdy3), 64'd0);
    rst3 = 1'b0;
    step();
    check("w3_rst_rdy", 64'(rdy3), 64'd1);
    check("w3_rst_rv", 64'(rv3), 64'd0);
    check("w3_rst_lcnt", 64'(lcnt3), 64'd0);
    check("w3_rst_scnt", 64'(scnt3), 64'd0);
    rst3 = 1'b1;
    step();
    step();
    step();
    check("w3_no_resume", 64'(rv3), 64'd0);

    $display("[TB] %0d tests run, %0d failed",
             tests_run, tests_failed);
    $finish;
  end

endmodule
